// File: rtl/piso_stream_if.sv
//------------------------------------------------------------------------------
// piso_stream_if : vector-in / beat-out handshake bundle for piso_stream
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface piso_stream_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 4,
    parameter int LANES    = 1
);
    logic                      IN_VALID;
    logic                      IN_READY;
    logic [WIDTH*NUM_TAPS-1:0] DATA_IN;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [WIDTH*LANES-1:0]    DATA_OUT;
    logic                      OUT_LAST;
    logic                      BUSY;

    // Streamer side
    modport slave (
        input  IN_VALID,
        input  DATA_IN,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output DATA_OUT,
        output OUT_LAST,
        output BUSY
    );

    // Producer/consumer side
    modport master (
        output IN_VALID,
        output DATA_IN,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  DATA_OUT,
        input  OUT_LAST,
        input  BUSY
    );
endinterface

`default_nettype wire

// File: rtl/piso_stream.sv
//------------------------------------------------------------------------------
// piso_stream : flow-controlled parallel-in/serial-out streamer, highest tap first.
// Optional holding buffer for bubble-free back-to-back vectors: PISO_DBUF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_stream #(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 4,
    parameter int LANES    = 1
) (
    input  wire logic     CLKEXT,
    input  wire logic     CLR,
    piso_stream_if.slave  bus
);

    localparam int BEATS = NUM_TAPS / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TOTW  = WIDTH * NUM_TAPS;
    localparam int BEATW = WIDTH * LANES;
    localparam logic [CW-1:0] C_LAST = CW'(BEATS - 1);

    generate
        if ((NUM_TAPS < 1) || (LANES < 1) || ((NUM_TAPS % LANES) != 0)) begin : g_cfg_check
            $error("piso_stream: NUM_TAPS must be >=1 and a multiple of LANES");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TOTW-1:0] shift_q, shift_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            last_q,  last_d;
    logic            busy_q,  busy_d;

    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_last_xfer;

`ifdef PISO_DBUF_EN
    logic [TOTW-1:0] buf_q, buf_d;
    logic            full_q, full_d;

    assign w_in_ready = !full_q && !CLR;
`else
    assign w_in_ready = (state_q == ST_IDLE) && !CLR;
`endif

    assign w_in_xfer   = bus.IN_VALID && w_in_ready;
    assign w_out_xfer  = (state_q == ST_SHIFT) && bus.OUT_READY;
    assign w_last_xfer = w_out_xfer && (cnt_q == C_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef PISO_DBUF_EN
        buf_d   = buf_q;
        full_d  = full_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_in_xfer) begin
                    shift_d = bus.DATA_IN;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_out_xfer && (cnt_q != C_LAST)) begin
                    shift_d = shift_q << BEATW;
                    cnt_d   = cnt_q + 1'b1;
                end else if (w_last_xfer) begin
`ifdef PISO_DBUF_EN
                    if (full_q) begin
                        shift_d = buf_q;
                        full_d  = 1'b0;
                        cnt_d   = '0;
                    end else if (w_in_xfer) begin
                        shift_d = bus.DATA_IN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef PISO_DBUF_EN
                // A vector arriving alongside the final beat with an empty buffer went straight to the shifter
                if (w_in_xfer && !(w_last_xfer && !full_q)) begin
                    buf_d  = bus.DATA_IN;
                    full_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        last_d = (state_d == ST_SHIFT) && (cnt_d == C_LAST);
`ifdef PISO_DBUF_EN
        busy_d = (state_d == ST_SHIFT) || full_d;
`else
        busy_d = (state_d == ST_SHIFT);
`endif
    end

    always_ff @(posedge CLKEXT) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PISO_DBUF_EN
            buf_q   <= '0;
            full_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef PISO_DBUF_EN
            buf_q   <= buf_d;
            full_q  <= full_d;
`endif
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = (state_q == ST_SHIFT);
    assign bus.DATA_OUT  = shift_q[TOTW-1 -: BEATW];
    assign bus.OUT_LAST  = last_q;
    assign bus.BUSY      = busy_q;

endmodule

`default_nettype wire
